reg_we_sched: RTL and testbench
===============================

// Module: reg_we_sched
// PURPOSE
//  Arbitrates register-write requests from NumReq hosts onto one shared register-file write port.
//  Grants one host at a time, round-robin, and drives a one-hot write-enable plus enable qualifier.
//  An external one-hot checker monitors these two outputs; its error is fed back on check_err_i
//  and locks the port until reset.
// PARAMETERS
//  NumReq   4   number of requesting hosts (>=2)
//  NumRegs  32  number of registers = width of we_oh_o (>=2)
//  AddrW    $clog2(NumRegs)  per-host register index width (derived, not overridable)
// PORTS
//  clk_i        in   1             clock
//  rst_ni       in   1             asynchronous active-low reset
//  req_i        in   NumReq        per-host write request; held until ack
//  addr_i       in   NumReq*AddrW  per-host register index, host h at [h*AddrW +: AddrW]
//  ack_o        out  NumReq        one-cycle completion pulse to the granted host
//  ack_err_o    out  1             qualifies ack_o: request rejected, no write performed
//  we_oh_o      out  NumRegs       one-hot register write-enable
//  we_en_o      out  1             write-enable valid; we_oh_o is all-zero when low
//  check_err_i  in   1             error from the downstream one-hot checker
//  fatal_o      out  1             sticky lock indication
//  busy_o       out  1             FSM not in IDLE
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; round-robin pointer=0 (host 0 highest priority).
//  FSM states: IDLE, WRITE, LOCKED. Every output is a register output.
//  IDLE:
//   - if any req_i, pick the winner h = first requester at or after pointer, wrapping modulo NumReq.
//   - latch h and addr_i[h]; pointer <= (h+1) mod NumReq.
//   - go to WRITE.
//  WRITE (exactly 1 cycle):
//   - addr < NumRegs: we_en_o=1, we_oh_o=1<<addr, ack_o[h]=1, ack_err_o=0.
//   - addr >= NumRegs (only possible when NumRegs is not a power of 2):
//     we_en_o=0, we_oh_o=0, ack_o[h]=1, ack_err_o=1.
//   - next state is IDLE.
//  Latency: req seen at edge t gives we/ack during cycle t+1. Back-to-back throughput is 1 write per 2 cycles.
//  A host that drops req_i after being latched still gets its write and ack; the write is committed.
//  A request may be re-arbitrated in IDLE only after its ack; a host must deassert or present
//   a new request in the cycle after ack.
//  check_err_i=1 in any state:
//   - next state LOCKED; fatal_o <= 1.
//   - an in-flight WRITE cycle completes as normal; a pending IDLE grant is abandoned.
//  LOCKED:
//   - we_en_o=0 and we_oh_o=0 permanently.
//   - each cycle, the round-robin winner (if any) gets ack_o[h]=1 with ack_err_o=1 and the pointer advances.
//   - exit only through rst_ni.
//  At most one ack_o bit is high in any cycle; ack_err_o=0 whenever ack_o=0.
//  Async reset mid-WRITE: outputs clear immediately; the write is lost and no ack is given.
// STRUCTURE
//  Shared package reg_we_sched_pkg: FSM state typedef (2-bit, encoded IDLE=2'b00, WRITE=2'b01, LOCKED=2'b10);
//   any illegal encoding is treated as LOCKED.
//  Sub-module reg_we_rr_arb: combinational round-robin pick from req vector and pointer;
//   outputs valid, index, one-hot grant.
//  The top holds the FSM, pointer, latched index/addr, and registered outputs.
// TESTING
//  1. NumReq=4, NumRegs=32, single req_i=4'b0010, addr1=5 -> next cycle we_oh_o=32'h20, we_en_o=1,
//     ack_o=4'b0010, ack_err_o=0; IDLE the cycle after.
//  2. req_i=4'b1111 held constant, pointer=0 -> acks in order hosts 0,1,2,3,0 every 2 cycles,
//     with we_en_o high only in ack cycles.
//  3. NumRegs=20, host 2 addr=25 -> ack_o=4'b0100 with ack_err_o=1, we_en_o=0, we_oh_o=0.
//  4. Pulse check_err_i during a WRITE for host 0 -> that write and its ack complete;
//     fatal_o=1 next cycle; later req from host 3 -> ack_err_o=1, we_en_o never rises.
//  5. Assert rst_ni=0 asynchronously mid-WRITE -> we_en_o, we_oh_o, ack_o clear immediately;
//     after release, req_i=4'b1000 wins with pointer=0 logic.
//  6. Host 1 drops req_i the cycle after being latched -> its write to its latched addr
//     still occurs and ack_o=4'b0010.

Source files
------------

// File: rtl/reg_we_sched_pkg.sv
// Shared definitions for the register write-enable scheduler.
// State encoding is fixed so that any stray encoding can be folded into LOCKED.
package reg_we_sched_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'b00;
    localparam state_t ST_WRITE  = 2'b01;
    localparam state_t ST_LOCKED = 2'b10;

    // Round-robin successor of a host index, wrapping at n.
    function automatic int rr_inc(input int idx, input int n);
        int nxt;
        if (idx + 1 >= n) begin
            nxt = 0;
        end else begin
            nxt = idx + 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/reg_we_rr_arb.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module reg_we_rr_arb #(
    parameter int NumReq = 4,
    parameter int PtrW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req,
    input  logic [PtrW-1:0]   ptr,
    output logic              valid,
    output logic [PtrW-1:0]   idx,
    output logic [NumReq-1:0] gnt
);

    // Scan from the farthest offset down so the nearest requester is assigned last and wins.
    always_comb begin
        int cand;
        valid = 1'b0;
        idx   = '0;
        gnt   = '0;
        cand  = 0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            cand = (int'(ptr) + i) % NumReq;
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand[PtrW-1:0];
            end else begin
                valid = valid;
            end
        end
        if (valid) begin
            gnt[idx] = 1'b1;
        end else begin
            gnt = '0;
        end
    end

endmodule

// File: rtl/reg_we_sched.sv
// Round-robin scheduler of register-file writes from several hosts onto one write port,
// with a sticky lock driven by an external one-hot checker.
module reg_we_sched #(
    parameter int NumReq  = 4,
    parameter int NumRegs = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumReq-1:0]                 req_i,
    input  logic [NumReq*$clog2(NumRegs)-1:0] addr_i,
    output logic [NumReq-1:0]                 ack_o,
    output logic                              ack_err_o,
    output logic [NumRegs-1:0]                we_oh_o,
    output logic                              we_en_o,
    input  logic                              check_err_i,
    output logic                              fatal_o,
    output logic                              busy_o
);
    import reg_we_sched_pkg::*;

    localparam int AddrW = $clog2(NumRegs);
    localparam int PtrW  = $clog2(NumReq);
    localparam logic [AddrW:0]     NumRegsW  = (AddrW + 1)'(NumRegs);
    localparam logic [NumRegs-1:0] OneHotLsb = {{(NumRegs - 1){1'b0}}, 1'b1};

    state_t              state_r;
    state_t              state_nxt_s;
    logic [PtrW-1:0]     ptr_r;
    logic [PtrW-1:0]     ptr_nxt_s;
    logic [NumReq-1:0]   arb_req_s;
    logic                arb_valid_s;
    logic [PtrW-1:0]     arb_idx_s;
    logic [NumReq-1:0]   arb_gnt_s;
    logic [AddrW-1:0]    win_addr_s;
    logic                addr_ok_s;
    logic [NumReq-1:0]   ack_nxt_s;
    logic                ack_err_nxt_s;
    logic [NumRegs-1:0]  we_oh_nxt_s;
    logic                we_en_nxt_s;
    logic                fatal_nxt_s;
    logic                busy_nxt_s;

    // A host being acked this cycle is still holding its request; mask it so it is not served twice.
    assign arb_req_s  = req_i & ~ack_o;
    assign win_addr_s = addr_i[arb_idx_s * AddrW +: AddrW];
    assign addr_ok_s  = ({1'b0, win_addr_s} < NumRegsW);

    reg_we_rr_arb #(
        .NumReq (NumReq),
        .PtrW   (PtrW)
    ) u_arb (
        .req    (arb_req_s),
        .ptr    (ptr_r),
        .valid  (arb_valid_s),
        .idx    (arb_idx_s),
        .gnt    (arb_gnt_s)
    );

    // Next-state and next-output logic; outputs are produced one edge ahead so the WRITE cycle shows them.
    always_comb begin
        state_nxt_s   = state_r;
        ptr_nxt_s     = ptr_r;
        ack_nxt_s     = '0;
        ack_err_nxt_s = 1'b0;
        we_oh_nxt_s   = '0;
        we_en_nxt_s   = 1'b0;
        fatal_nxt_s   = fatal_o;
        case (state_r)
            ST_IDLE: begin
                if (check_err_i) begin
                    state_nxt_s = ST_LOCKED;
                    fatal_nxt_s = 1'b1;
                end else if (arb_valid_s) begin
                    state_nxt_s = ST_WRITE;
                    ptr_nxt_s   = PtrW'(rr_inc(int'(arb_idx_s), NumReq));
                    ack_nxt_s   = arb_gnt_s;
                    if (addr_ok_s) begin
                        we_en_nxt_s = 1'b1;
                        we_oh_nxt_s = OneHotLsb << win_addr_s;
                    end else begin
                        ack_err_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (check_err_i) begin
                    state_nxt_s = ST_LOCKED;
                    fatal_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                // LOCKED and any corrupted encoding: reject every request, never write.
                state_nxt_s = ST_LOCKED;
                fatal_nxt_s = 1'b1;
                if (arb_valid_s) begin
                    ptr_nxt_s     = PtrW'(rr_inc(int'(arb_idx_s), NumReq));
                    ack_nxt_s     = arb_gnt_s;
                    ack_err_nxt_s = 1'b1;
                end else begin
                    ack_nxt_s = '0;
                end
            end
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State, pointer and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= ST_IDLE;
            ptr_r     <= '0;
            ack_o     <= '0;
            ack_err_o <= 1'b0;
            we_oh_o   <= '0;
            we_en_o   <= 1'b0;
            fatal_o   <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            ptr_r     <= ptr_nxt_s;
            ack_o     <= ack_nxt_s;
            ack_err_o <= ack_err_nxt_s;
            we_oh_o   <= we_oh_nxt_s;
            we_en_o   <= we_en_nxt_s;
            fatal_o   <= fatal_nxt_s;
            busy_o    <= busy_nxt_s;
        end
    end

endmodule

// File: tb/tb_reg_we_sched.sv
// Scoreboard bench for reg_we_sched (4 hosts, 20 registers so out-of-range indices occur).
module tb_reg_we_sched;

    localparam int NR  = 4;
    localparam int NG  = 20;
    localparam int AW  = 5;

    logic            clk_i;
    logic            rst_ni;
    logic [NR-1:0]   req_i;
    logic [NR*AW-1:0] addr_i;
    logic [NR-1:0]   ack_o;
    logic            ack_err_o;
    logic [NG-1:0]   we_oh_o;
    logic            we_en_o;
    logic            check_err_i;
    logic            fatal_o;
    logic            busy_o;

    reg_we_sched #(.NumReq(NR), .NumRegs(NG)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .addr_i      (addr_i),
        .ack_o       (ack_o),
        .ack_err_o   (ack_err_o),
        .we_oh_o     (we_oh_o),
        .we_en_o     (we_en_o),
        .check_err_i (check_err_i),
        .fatal_o     (fatal_o),
        .busy_o      (busy_o)
    );

    typedef struct {
        int          cyc;
        logic        we_en;
        logic [31:0] we_oh;
        logic [3:0]  ack;
        logic        ack_err;
        logic        fatal;
        logic        busy;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc_cnt  = 0;

    // reference model state: what the DUT shows in the current cycle
    logic [3:0]  m_ack;
    bit          m_write;
    bit          m_locked;
    int          m_ptr;

    // host behaviour state
    logic [3:0]  hreq;
    logic [4:0]  haddr [4];
    logic [3:0]  prev_ack;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endfunction

    function automatic int pick(input logic [3:0] r, input int p);
        for (int i = 0; i < NR; i++) begin
            int c;
            c = (p + i) % NR;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ack    = 4'b0000;
        m_write  = 1'b0;
        m_locked = 1'b0;
        m_ptr    = 0;
        hreq     = 4'b0000;
        prev_ack = 4'b0000;
    endtask

    // Predict the outputs of the next cycle from the inputs just driven.
    task automatic model(input logic [3:0] r, input logic ce);
        exp_t e;
        int   w;
        e.cyc = cyc_cnt + 1;
        e.we_en = 1'b0; e.we_oh = 32'h0; e.ack = 4'b0000;
        e.ack_err = 1'b0; e.fatal = m_locked; e.busy = m_locked;
        if (m_locked) begin
            w = pick(r & ~m_ack, m_ptr);
            if (w >= 0) begin
                e.ack = 4'b0001 << w;
                e.ack_err = 1'b1;
                m_ptr = (w + 1) % NR;
            end
        end else if (m_write || ce) begin
            m_write = 1'b0;
            if (ce) begin
                m_locked = 1'b1;
                e.fatal = 1'b1;
                e.busy = 1'b1;
            end
        end else begin
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_write = 1'b1;
                e.busy = 1'b1;
                m_ptr = (w + 1) % NR;
                e.ack = 4'b0001 << w;
                if (int'(haddr[w]) < NG) begin
                    e.we_en = 1'b1;
                    e.we_oh = 32'h1 << haddr[w];
                end else begin
                    e.ack_err = 1'b1;
                end
            end
        end
        m_ack = e.ack;
        q.push_back(e);
    endtask

    task automatic step(input logic [3:0] r, input logic ce);
        @(posedge clk_i);
        #1;
        req_i = r;
        check_err_i = ce;
        for (int h = 0; h < NR; h++) addr_i[h*AW +: AW] = haddr[h];
        model(r, ce);
    endtask

    // Random hosts: hold until ack, then drop or re-request in the cycle after ack; rarely drop early.
    task automatic rand_step(input bit allow_ce);
        logic ce;
        for (int h = 0; h < NR; h++) begin
            if (prev_ack[h]) begin
                hreq[h]  = 1'($urandom_range(1, 0));
                haddr[h] = 5'($urandom_range(31, 0));
            end else if (m_ack[h]) begin
                hreq[h] = hreq[h];
            end else if (hreq[h]) begin
                if ($urandom_range(15, 0) == 0) hreq[h] = 1'b0;
            end else if ($urandom_range(2, 0) == 0) begin
                hreq[h]  = 1'b1;
                haddr[h] = 5'($urandom_range(31, 0));
            end
        end
        prev_ack = m_ack;
        ce = allow_ce && ($urandom_range(7, 0) == 0);
        step(hreq, ce);
    endtask

    // Monitor: compare every predicted cycle against the DUT outputs.
    initial begin
        forever begin
            @(negedge clk_i);
            while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
                exp_t e;
                e = q.pop_front();
                chk("we_en", {31'b0, we_en_o}, {31'b0, e.we_en});
                chk("we_oh", {12'b0, we_oh_o}, e.we_oh);
                chk("ack", {28'b0, ack_o}, {28'b0, e.ack});
                chk("ack_err", {31'b0, ack_err_o}, {31'b0, e.ack_err});
                chk("fatal", {31'b0, fatal_o}, {31'b0, e.fatal});
                chk("busy", {31'b0, busy_o}, {31'b0, e.busy});
            end
        end
    end

    initial begin
        rst_ni = 1'b0;
        req_i = 4'b0000;
        addr_i = '0;
        check_err_i = 1'b0;
        for (int h = 0; h < NR; h++) haddr[h] = 5'd0;
        model_reset();
        #12;
        chk("rst_outputs", {12'b0, we_oh_o}, 32'h0);
        chk("rst_flags", {26'b0, ack_o, we_en_o, ack_err_o}, 32'h0);
        chk("rst_status", {30'b0, fatal_o, busy_o}, 32'h0);
        #10;
        rst_ni = 1'b1;

        // single host 1 writes register 5
        haddr[1] = 5'd5;
        step(4'b0010, 1'b0); step(4'b0010, 1'b0); step(4'b0000, 1'b0); step(4'b0000, 1'b0);
        // all hosts held: round-robin 0,1,2,3,0...
        haddr[0] = 5'd3; haddr[1] = 5'd7; haddr[2] = 5'd11; haddr[3] = 5'd15;
        repeat (10) step(4'b1111, 1'b0);
        step(4'b0000, 1'b0);
        // host 2 out-of-range index
        haddr[2] = 5'd25;
        step(4'b0100, 1'b0); step(4'b0100, 1'b0); step(4'b0000, 1'b0);
        // host 1 drops right after being latched
        haddr[1] = 5'd13;
        step(4'b0010, 1'b0); step(4'b0000, 1'b0); step(4'b0000, 1'b0);

        repeat (300) rand_step(1'b0);
        hreq = 4'b0000;
        repeat (3) step(4'b0000, 1'b0);

        // async reset in the middle of a write
        haddr[3] = 5'd9;
        step(4'b1000, 1'b0);
        @(posedge clk_i);
        #2;
        chk("pre_rst_we_en", {31'b0, we_en_o}, 32'h1);
        #1;
        rst_ni = 1'b0;
        req_i = 4'b0000;
        q.delete();
        #1;
        chk("async_rst_we", {11'b0, we_en_o, we_oh_o}, 32'h0);
        chk("async_rst_ack", {27'b0, ack_o, ack_err_o}, 32'h0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
        step(4'b1000, 1'b0); step(4'b1000, 1'b0); step(4'b0000, 1'b0); step(4'b0000, 1'b0);

        // checker error during host 0 write, then host 3 is rejected
        haddr[0] = 5'd4;
        step(4'b0001, 1'b0); step(4'b0001, 1'b1); step(4'b0000, 1'b0);
        step(4'b1000, 1'b0); step(4'b1000, 1'b0); step(4'b0000, 1'b0);

        hreq = 4'b0000;
        prev_ack = 4'b0000;
        repeat (200) rand_step(1'b1);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk_i);
        #1;
        chk("drain", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
